// File: rtl/prio_scan.sv
// Set-bit iterator: accepts a WIDTH-bit vector and streams the index of every set bit,
// LSB-first or MSB-first, one index per output handshake.
module prio_scan #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;

  logic [IDXW-1:0]  lo_idx, hi_idx;
  logic [WIDTH-1:0] clr_mask;
  logic             work_zero, work_onehot;
  logic             accept, out_hs;

  // Priority encoders: the last assignment in each loop wins.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (work_q[i]) lo_idx = IDXW'(i);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (work_q[i]) hi_idx = IDXW'(i);
    end
  end

  assign work_zero   = (work_q == '0);
  assign work_onehot = !work_zero && ((work_q & (work_q - WIDTH'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
    end
  end

  // Beat fields depend only on registered state; only in_ready looks at out_ready/flush.
  always_comb begin
    out_valid = (state_q == StEmit);
    out_zero  = out_valid && work_zero;
    out_last  = out_valid && (work_zero || work_onehot);
    out_idx   = '0;
    if (out_valid) out_idx = dir_q ? hi_idx : lo_idx;
    in_ready  = !flush && ((state_q == StIdle) || (out_last && out_ready));
  end

  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign clr_mask = WIDTH'(1) << out_idx;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    if (flush) begin
      state_d = StIdle;
      work_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StEmit: begin
          if (out_hs) begin
            work_d = work_q & ~clr_mask;
            if (out_last) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      // A new vector may replace the final beat in the same cycle.
      if (accept) begin
        work_d  = in_vec;
        dir_d   = in_dir;
        state_d = StEmit;
      end
    end
  end

endmodule

// File: tb/tb_prio_scan.sv
// Directed and randomised checks of prio_scan at WIDTH=24 and WIDTH=37.
module tb_prio_scan;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_dir, out_ready, sel;
  logic [36:0] vec;

  logic       a_in_valid, a_in_ready, a_out_valid, a_last, a_zero;
  logic [4:0] a_idx;
  logic       b_in_valid, b_in_ready, b_out_valid, b_last, b_zero;
  logic [5:0] b_idx;

  logic       obs_in_ready, obs_out_valid, obs_last, obs_zero;
  logic [5:0] obs_idx;

  int checks = 0;
  int errors = 0;
  int got_idx[$];
  bit got_last[$];
  bit got_zero[$];
  bit timeout;

  always #5 clk = ~clk;

  assign a_in_valid    = in_valid & ~sel;
  assign b_in_valid    = in_valid & sel;
  assign obs_in_ready  = sel ? b_in_ready : a_in_ready;
  assign obs_out_valid = sel ? b_out_valid : a_out_valid;
  assign obs_idx       = sel ? b_idx : {1'b0, a_idx};
  assign obs_last      = sel ? b_last : a_last;
  assign obs_zero      = sel ? b_zero : a_zero;

  prio_scan #(.WIDTH(24)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_vec    (vec[23:0]),
    .in_dir    (in_dir),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_idx   (a_idx),
    .out_last  (a_last),
    .out_zero  (a_zero)
  );

  prio_scan #(.WIDTH(37)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_vec    (vec),
    .in_dir    (in_dir),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_idx   (b_idx),
    .out_last  (b_last),
    .out_zero  (b_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [36:0] v, input logic d);
    int n;
    vec = v; in_dir = d; in_valid = 1'b1;
    #1;
    n = 0;
    while (!obs_in_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (n == 50) begin
      errors++;
      $display("FAIL send_accept: in_ready stayed %0b, required 1 within 50 cycles", obs_in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Record beats until the last one is taken; rnd randomises out_ready.
  task automatic collect(input bit rnd);
    bit fin;
    got_idx.delete(); got_last.delete(); got_zero.delete();
    timeout = 1'b1;
    for (int c = 0; c < 400; c++) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      fin = obs_out_valid && out_ready && obs_last;
      if (obs_out_valid && out_ready) begin
        got_idx.push_back(int'(obs_idx));
        got_last.push_back(obs_last);
        got_zero.push_back(obs_zero);
      end
      tick();
      if (fin) begin
        timeout = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dir = 1'b0;
    out_ready = 1'b1; sel = 1'b0; vec = '0;
    #3;
    checks++;
    if ({a_in_ready, a_out_valid, a_idx, a_last, a_zero} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: rdy/vld/idx/last/zero=%b/%b/%0d/%b/%b required 1/0/0/0/0",
               a_in_ready, a_out_valid, a_idx, a_last, a_zero);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_idx} !== {1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL reset_b: rdy/vld/idx=%b/%b/%0d required 1/0/0", b_in_ready, b_out_valid, b_idx);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_order(input string name, input logic [36:0] v, input logic d,
                            input int n, input int e0, input int e1, input int e2,
                            input int e3, input int e4, input bit z);
    int exp_idx[5];
    bit ok;
    exp_idx = '{e0, e1, e2, e3, e4};
    send(v, d);
    collect(1'b0);
    ok = !timeout && (got_idx.size() == n);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        if (got_idx[i] != exp_idx[i] || got_last[i] != (i == n - 1) || got_zero[i] != z) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d beats idx %p last %p zero %p, required %0d beats idx %p zero %0b",
               name, got_idx.size(), got_idx, got_last, got_zero, n, exp_idx, z);
    end
    #1;
    checks++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: in_ready=%b out_valid=%b required 1/0", name, obs_in_ready,
               obs_out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(37'h000012, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({obs_out_valid, obs_idx, obs_last} !== {1'b1, 6'd1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: vld/idx/last=%b/%0d/%b required 1/1/0", i, obs_out_valid,
                 obs_idx, obs_last);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({obs_out_valid, obs_idx, obs_last} !== {1'b1, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: vld/idx/last=%b/%0d/%b required 1/1/0", obs_out_valid,
               obs_idx, obs_last);
    end
    tick();
    vec = 37'h400001; in_dir = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_idx, obs_last} !== {1'b1, 1'b1, 6'd4, 1'b1}) begin
      errors++;
      $display("FAIL b2b_last: rdy/vld/idx/last=%b/%b/%0d/%b required 1/1/4/1", obs_in_ready,
               obs_out_valid, obs_idx, obs_last);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({obs_out_valid, obs_idx, obs_last} !== {1'b1, 6'd22, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: vld/idx/last=%b/%0d/%b required 1/22/0", obs_out_valid, obs_idx,
               obs_last);
    end
    tick();
    #1;
    checks++;
    if ({obs_out_valid, obs_idx, obs_last} !== {1'b1, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: vld/idx/last=%b/%0d/%b required 1/0/1", obs_out_valid, obs_idx,
               obs_last);
    end
    tick();
    #1;
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b required 0", obs_out_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(37'hFFFFFF, 1'b0);
    #1;
    checks++;
    if ({obs_out_valid, obs_idx} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL flush_beat0: vld/idx=%b/%0d required 1/0", obs_out_valid, obs_idx);
    end
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if ({obs_out_valid, obs_idx, obs_in_ready} !== {1'b1, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL flush_cycle: vld/idx/in_ready=%b/%0d/%b required 1/1/0", obs_out_valid,
               obs_idx, obs_in_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({obs_out_valid, obs_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b in_ready=%b required 0/1", obs_out_valid,
               obs_in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(37'hFFFFFF, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({obs_out_valid, obs_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b required 0/1", obs_out_valid,
               obs_in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    test_order("after_reset", 37'h000008, 1'b0, 1, 3, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random(input bit s, input int w, input int n);
    logic [63:0] r1, r2, r3;
    logic [36:0] v, wmask;
    logic        d;
    int          exp_idx[$];
    bit          ok;
    int          mode;
    sel = s;
    tick();
    wmask = (37'h1 << w) - 37'h1;
    for (int k = 0; k < n; k++) begin
      r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      v = r1[36:0];
      if (mode == 0) v = '0;
      else if (mode < 4) v = r1[36:0] & r2[36:0] & r3[36:0];
      v = v & wmask;
      d = 1'($urandom_range(0, 1));
      exp_idx.delete();
      if (v == '0) exp_idx.push_back(0);
      else if (!d) begin
        for (int i = 0; i < w; i++) if (v[i]) exp_idx.push_back(i);
      end else begin
        for (int i = w - 1; i >= 0; i--) if (v[i]) exp_idx.push_back(i);
      end
      send(v, d);
      collect(1'b1);
      ok = !timeout && (got_idx.size() == exp_idx.size());
      if (ok) begin
        for (int i = 0; i < exp_idx.size(); i++) begin
          if (got_idx[i] != exp_idx[i] || got_last[i] != (i == exp_idx.size() - 1) ||
              got_zero[i] != (v == '0)) ok = 1'b0;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_w%0d vec=%h dir=%0b: got %0d beats %p, required %0d beats %p",
                 w, v, d, got_idx.size(), got_idx, exp_idx.size(), exp_idx);
      end
    end
    sel = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_order("lsb_first", 37'h000097, 1'b0, 5, 0, 1, 2, 4, 7, 1'b0);
    test_order("msb_first", 37'h000097, 1'b1, 5, 7, 4, 2, 1, 0, 1'b0);
    test_order("zero_vec", 37'h000000, 1'b0, 1, 0, 0, 0, 0, 0, 1'b1);
    test_order("top_bit", 37'h800000, 1'b0, 1, 23, 0, 0, 0, 0, 1'b0);
    test_order("top_bit_msb", 37'h800000, 1'b1, 1, 23, 0, 0, 0, 0, 1'b0);
    test_back_to_back();
    test_flush();
    test_reset_mid();
    sel = 1'b1;
    test_order("w37_top", 37'h10_0000_0001, 1'b1, 2, 36, 0, 0, 0, 0, 1'b0);
    test_random(1'b0, 24, 1000);
    test_random(1'b1, 37, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
